// File: rtl/vit_frame_ctrl.sv
// vit_frame_ctrl
// Frame sequencer for a rate-1/2, K=3 (4-state) Viterbi decoder.
// It accepts FRAME_LEN symbol pairs, strobes the ACS stage and writes one
// survivor word per symbol. It then runs a traceback from state 0 (the frame
// is tail-terminated) and emits decoded bits, last symbol first.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a frame (honoured only when idle)
//   sym_valid         upstream symbol pair valid
//   sym_ready         symbol accepted this cycle when sym_valid is high
//   acs_clr           one-cycle path-metric initialise pulse
//   acs_en            ACS update strobe (sym_valid & sym_ready)
//   wr_en, wr_addr    survivor-memory write port (symbol index)
//   rd_en, rd_addr    survivor-memory read port (synchronous RAM)
//   surv_in           survivor word, bit[s] = decision for state s
//   dec_bit/valid/last decoded bit stream, dec_last marks symbol index 0
//   busy              high whenever a frame is in progress
module vit_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 32,
  parameter int unsigned AW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sym_valid,
  output logic          sym_ready,
  output logic          acs_clr,
  output logic          acs_en,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [3:0]    surv_in,
  output logic          dec_bit,
  output logic          dec_valid,
  output logic          dec_last,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACQ,
    WAIT,
    TB,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] sym_cnt_q, sym_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]    s_q, s_d;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic          dec_valid_q;
  logic          dec_last_q;

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    s_d       = s_q;
    sym_ready = 1'b0;
    acs_clr   = 1'b0;
    rd_en     = 1'b0;

    // Read data for the previous rd_en arrives now: step the traceback
    // state along the stored decision of the current state.
    if (dec_valid_q) begin
      s_d = {s_q[0], surv_in[s_q]};
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
        end
      end
      CLR: begin
        acs_clr   = 1'b1;
        sym_cnt_d = '0;
        state_d   = ACQ;
      end
      ACQ: begin
        sym_ready = 1'b1;
        if (sym_valid) begin
          if (sym_cnt_q == LAST_IDX) begin
            sym_cnt_d = '0;
            state_d   = WAIT;
          end else begin
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        // Frame is tail-terminated, so traceback always starts at state 0.
        rd_cnt_d = LAST_IDX;
        s_d      = '0;
        state_d  = TB;
      end
      TB: begin
        rd_en = 1'b1;
        if (rd_cnt_q == '0) begin
          state_d = DRAIN;
        end else begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sym_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      s_q         <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      dec_valid_q <= 1'b0;
      dec_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      s_q         <= s_d;
      wr_en_q     <= acs_en;
      if (acs_en) begin
        wr_addr_q <= sym_cnt_q;
      end
      dec_valid_q <= rd_en;
      dec_last_q  <= rd_en && (rd_cnt_q == '0);
    end
  end

  assign acs_en    = sym_valid & sym_ready;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign rd_addr   = rd_en ? rd_cnt_q : '0;
  assign dec_valid = dec_valid_q;
  assign dec_last  = dec_last_q;
  assign dec_bit   = dec_valid_q & s_q[1];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vit_frame_ctrl.sv
module tb_vit_frame_ctrl;

  localparam int F  = 5;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sym_valid;
  logic          sym_ready;
  logic          acs_clr;
  logic          acs_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [3:0]    surv_in;
  logic          dec_bit;
  logic          dec_valid;
  logic          dec_last;
  logic          busy;

  vit_frame_ctrl #(.FRAME_LEN(F), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .acs_clr   (acs_clr),
    .acs_en    (acs_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .surv_in   (surv_in),
    .dec_bit   (dec_bit),
    .dec_valid (dec_valid),
    .dec_last  (dec_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_cnt = 0;
  int first_rd = -1;
  int first_dec = -1;
  int last_dec = -1;

  logic [3:0]    wq[$];     // survivor words the ACS datapath would write, in order
  logic [AW-1:0] wr_q[$];   // expected write addresses
  logic [AW-1:0] rd_q[$];   // expected read addresses
  logic [1:0]    dec_q[$];  // expected {dec_last, dec_bit}

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Survivor RAM: synchronous read, written with the datapath's words.
  logic [3:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (wr_en) begin
      if (wq.size() > 0) mem[wr_addr] <= wq.pop_front();
      else               mem[wr_addr] <= 4'($urandom);
    end
    if (rd_en) surv_in <= mem[rd_addr];
    else       surv_in <= 4'($urandom);
  end

  // Monitor: samples on the falling edge, pops expected beats.
  always @(negedge clk) begin
    if (!rst) begin
      logic [1:0] e;
      chk("acs_en", int'(acs_en), int'(sym_valid & sym_ready));
      if (acs_clr) clr_cnt++;
      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_extra", 1, 0);
        else chk("wr_addr", int'(wr_addr), int'(wr_q.pop_front()));
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (rd_q.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", int'(rd_addr), int'(rd_q.pop_front()));
      end
      if (dec_valid) begin
        if (first_dec < 0) first_dec = cyc;
        last_dec = cyc;
        if (dec_q.size() == 0) chk("dec_extra", 1, 0);
        else begin
          e = dec_q.pop_front();
          chk("dec_bit", int'(dec_bit), int'(e[0]));
          chk("dec_last", int'(dec_last), int'(e[1]));
        end
      end else begin
        chk("dec_last_idle", int'(dec_last), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int all_outs();
    return int'({sym_ready, acs_clr, acs_en, wr_en, wr_addr, rd_en, rd_addr,
                 dec_bit, dec_valid, dec_last, busy});
  endfunction

  // mode: 0 all-zero survivors, 1 all-ones, 2 random
  task automatic run_frame(input int mode, input int stall_pct, input bit hold, input bit do_rst);
    logic [3:0] w [F];
    logic [1:0] s;
    int acc, guard, last_acc, clr_before, clr_cyc, idle_cyc, n;
    for (int i = 0; i < F; i++) begin
      w[i] = (mode == 0) ? 4'h0 : (mode == 1) ? 4'hF : 4'($urandom);
      wq.push_back(w[i]);
      wr_q.push_back(AW'(i));
    end
    // Traceback from state 0, newest symbol first; output bit is the MSB of the state.
    s = 2'b00;
    for (int t = F - 1; t >= 0; t--) begin
      rd_q.push_back(AW'(t));
      dec_q.push_back({t == 0, s[1]});
      s = {s[0], w[t][s]};
    end
    first_rd = -1; first_dec = -1; last_dec = -1;
    clr_before = clr_cnt;

    start = 1'b1;
    tick();
    chk("clr_after_start", int'(acs_clr), 1);
    chk("busy_in_clr", int'(busy), 1);
    clr_cyc = cyc;
    start = hold;
    sym_valid = ($urandom_range(0, 1) == 1);

    acc = 0; guard = 0; last_acc = 0;
    while (acc < F && guard < 500) begin
      tick();
      guard++;
      sym_valid = ($urandom_range(0, 99) >= stall_pct);
      if (!hold) start = ($urandom_range(0, 7) == 0);
      if (sym_valid && sym_ready) begin
        acc++;
        last_acc = cyc;
      end
    end
    if (acc < F) chk("acq_timeout", acc, F);

    if (do_rst) begin
      n = 0; guard = 0;
      while (n < 2 && guard < 100) begin
        tick();
        guard++;
        if (dec_valid) n++;
      end
      if (n < 2) chk("rst_wait_timeout", n, 2);
      rst = 1'b1;
      #1;
      chk("outs_in_reset", all_outs(), 0);
      wq.delete(); wr_q.delete(); rd_q.delete(); dec_q.delete();
      start = 1'b0;
      sym_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
        sym_valid = ($urandom_range(0, 1) == 1);
        tick();
        chk("idle_after_rst", int'(busy), 0);
      end
      sym_valid = 1'b0;
      return;
    end

    guard = 0;
    forever begin
      tick();
      guard++;
      if (!busy || guard > 200) break;
      sym_valid = ($urandom_range(0, 1) == 1);
      if (!hold) start = ($urandom_range(0, 7) == 0);
    end
    if (busy) chk("idle_timeout", 1, 0);
    start = hold;
    sym_valid = ($urandom_range(0, 1) == 1);
    idle_cyc = cyc;

    chk("first_rd", first_rd, last_acc + 2);
    chk("first_dec", first_dec, last_acc + 3);
    chk("last_dec", last_dec, last_acc + 2 + F);
    chk("idle_cycle", idle_cyc, last_acc + 3 + F);
    chk("clr_pulses", clr_cnt - clr_before, 1);
    if (stall_pct == 0) chk("frame_time", idle_cyc - clr_cyc + 1, 2 * F + 4);
    chk("wr_left", wr_q.size(), 0);
    chk("rd_left", rd_q.size(), 0);
    chk("dec_left", dec_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sym_valid = 1'b0;
    tick(); tick();
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    sym_valid = 1'b1;
    tick();
    chk("idle_ready", int'(sym_ready), 0);
    chk("idle_busy", int'(busy), 0);
    sym_valid = 1'b0;

    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(1, 0, 1'b0, 1'b0);
    run_frame(2, 50, 1'b0, 1'b0);
    run_frame(2, 30, 1'b0, 1'b1);
    run_frame(2, 0, 1'b0, 1'b0);
    run_frame(2, 20, 1'b1, 1'b0);
    run_frame(2, 0, 1'b1, 1'b0);
    run_frame(2, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_frame(2, int'($urandom_range(0, 60)), 1'b0, 1'b0);
    end
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
